// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: paddle and ball motion, wall/paddle reflection,
// scoring and the serve/hold/game-over FSM, all stepped once per VSYNC tick.
module pong_game_ctrl #(
    parameter int BALL_STEP   = 4,
    parameter int PAD_STEP    = 6,
    parameter int BALL_SIZE   = 4,
    parameter int PAD_HALF_H  = 47,
    parameter int PAD_HALF_W  = 2,
    parameter int PAD_LX      = 20,
    parameter int PAD_RX      = 619,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       up_l,
    input  logic       dn_l,
    input  logic       up_r,
    input  logic       dn_r,
    input  logic       serve,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic [9:0] paddleLX,
    output logic [9:0] paddleLY,
    output logic [9:0] paddleRX,
    output logic [9:0] paddleRY,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic signed [10:0] STEP  = 11'(BALL_STEP);
    localparam logic signed [10:0] SIZE  = 11'(BALL_SIZE);
    localparam logic signed [10:0] PSTEP = 11'(PAD_STEP);
    localparam logic signed [10:0] PTOP  = 11'(PAD_HALF_H);
    localparam logic signed [10:0] PBOT  = 11'(479 - PAD_HALF_H);
    localparam logic signed [10:0] REACH = 11'(PAD_HALF_H + BALL_SIZE);
    localparam logic signed [10:0] LFACE = 11'(PAD_LX + PAD_HALF_W);
    localparam logic signed [10:0] RFACE = 11'(PAD_RX - PAD_HALF_W);
    localparam logic signed [10:0] YMAX  = 11'sd479;
    localparam logic signed [10:0] XMAX  = 11'sd639;
    localparam logic signed [10:0] ZERO  = 11'sd0;
    localparam logic signed [10:0] ONE   = 11'sd1;
    localparam logic [9:0]         CX    = 10'd320;
    localparam logic [9:0]         CY    = 10'd240;
    localparam logic [3:0]         WIN   = 4'(WIN_SCORE);
    localparam logic [7:0]         HOLDN = 8'(HOLD_FRAMES);

    logic [1:0]        sync_q;
    logic              edge_q;
    logic              tick;
    state_t            st_q, st_d;
    logic [9:0]        bx_q, bx_d, by_q, by_d;
    logic [9:0]        ly_q, ly_d, ry_q, ry_d;
    logic signed [10:0] mx_q, mx_d, my_q, my_d;
    logic [3:0]        sl_q, sl_d, sr_q, sr_d;
    logic [7:0]        hold_q, hold_d;
    logic              dir_q, dir_d;

    logic signed [10:0] bxs, bys, nx, ny, mxn, myn, dyl, dyr;
    logic               hit_l, hit_r, miss_l, miss_r;

    assign tick = sync_q[1] & ~edge_q;

    function automatic logic [9:0] pad_move(input logic [9:0] y,
                                            input logic up,
                                            input logic dn);
        logic signed [10:0] t;
        t = signed'({1'b0, y});
        if (up && !dn)
            t = t - PSTEP;
        else if (dn && !up)
            t = t + PSTEP;
        if (t < PTOP)
            t = PTOP;
        else if (t > PBOT)
            t = PBOT;
        return t[9:0];
    endfunction

    // Hit tests look at the paddle position from before this frame's move.
    always_comb begin
        bxs = signed'({1'b0, bx_q});
        bys = signed'({1'b0, by_q});
        nx  = bxs + mx_q;
        ny  = bys + my_q;
        mxn = mx_q;
        myn = my_q;
        dyl = bys - signed'({1'b0, ly_q});
        dyr = bys - signed'({1'b0, ry_q});
        if (dyl < ZERO)
            dyl = -dyl;
        if (dyr < ZERO)
            dyr = -dyr;
        if (my_q > ZERO && ny + SIZE >= YMAX) begin
            ny  = YMAX - SIZE;
            myn = -STEP;
        end else if (my_q < ZERO && ny - SIZE <= ZERO) begin
            ny  = SIZE;
            myn = STEP;
        end
        hit_l  = (mx_q < ZERO) && (nx - SIZE <= LFACE) && (dyl <= REACH);
        hit_r  = (mx_q > ZERO) && (nx + SIZE >= RFACE) && (dyr <= REACH);
        miss_l = !hit_l && !hit_r && (nx - SIZE <= ZERO);
        miss_r = !hit_l && !hit_r && (nx + SIZE >= XMAX);
        if (hit_l) begin
            nx  = LFACE + SIZE + ONE;
            mxn = STEP;
        end else if (hit_r) begin
            nx  = RFACE - SIZE - ONE;
            mxn = -STEP;
        end
    end

    always_comb begin
        st_d   = st_q;
        bx_d   = bx_q;
        by_d   = by_q;
        ly_d   = ly_q;
        ry_d   = ry_q;
        mx_d   = mx_q;
        my_d   = my_q;
        sl_d   = sl_q;
        sr_d   = sr_q;
        hold_d = hold_q;
        dir_d  = dir_q;
        if (tick) begin
            unique case (st_q)
                IDLE: begin
                    ly_d = pad_move(ly_q, up_l, dn_l);
                    ry_d = pad_move(ry_q, up_r, dn_r);
                    bx_d = CX;
                    by_d = CY;
                    if (serve) begin
                        st_d  = PLAY;
                        mx_d  = dir_q ? -STEP : STEP;
                        my_d  = STEP;
                        dir_d = ~dir_q;
                    end
                end
                PLAY: begin
                    ly_d = pad_move(ly_q, up_l, dn_l);
                    ry_d = pad_move(ry_q, up_r, dn_r);
                    if (miss_l || miss_r) begin
                        st_d   = HOLD;
                        mx_d   = ZERO;
                        my_d   = ZERO;
                        hold_d = HOLDN;
                        if (miss_l && sr_q < WIN)
                            sr_d = sr_q + 4'd1;
                        if (miss_r && sl_q < WIN)
                            sl_d = sl_q + 4'd1;
                    end else begin
                        bx_d = nx[9:0];
                        by_d = ny[9:0];
                        mx_d = mxn;
                        my_d = myn;
                    end
                end
                HOLD: begin
                    if (hold_q <= 8'd1) begin
                        hold_d = 8'd0;
                        if (sl_q == WIN || sr_q == WIN) begin
                            st_d = OVER;
                        end else begin
                            st_d = IDLE;
                            bx_d = CX;
                            by_d = CY;
                        end
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                OVER: begin
                    if (serve) begin
                        st_d  = IDLE;
                        sl_d  = 4'd0;
                        sr_d  = 4'd0;
                        dir_d = 1'b0;
                        bx_d  = CX;
                        by_d  = CY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
            st_q   <= IDLE;
            bx_q   <= CX;
            by_q   <= CY;
            ly_q   <= CY;
            ry_q   <= CY;
            mx_q   <= ZERO;
            my_q   <= ZERO;
            sl_q   <= 4'd0;
            sr_q   <= 4'd0;
            hold_q <= 8'd0;
            dir_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], frame_clk};
            edge_q <= sync_q[1];
            st_q   <= st_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            ly_q   <= ly_d;
            ry_q   <= ry_d;
            mx_q   <= mx_d;
            my_q   <= my_d;
            sl_q   <= sl_d;
            sr_q   <= sr_d;
            hold_q <= hold_d;
            dir_q  <= dir_d;
        end
    end

    assign BallX     = bx_q;
    assign BallY     = by_q;
    assign Ball_size = 10'(BALL_SIZE);
    assign paddleLX  = 10'(PAD_LX);
    assign paddleLY  = ly_q;
    assign paddleRX  = 10'(PAD_RX);
    assign paddleRY  = ry_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign state     = st_q;

endmodule
